// File: rtl/mem_access_unit.sv
// Load/store/fetch access unit: decodes MIPS load/store opcodes into single-beat
// Avalon-MM transfers and returns the lane-extracted, extended load result.
module mem_access_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_fetch,
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [DATA_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  state_e state_q, state_d;

  // Decoded view of the request currently on the input ports
  size_e             dec_size;
  logic              dec_signed;
  logic              dec_store;
  logic              dec_err;
  logic [3:0]        dec_be;
  logic [DATA_W-1:0] dec_wdata;

  // Attributes of the captured request, used while the bus completes
  size_e             size_q;
  logic              signed_q;
  logic              store_q;
  logic [1:0]        lane_q;

  logic              bus_done;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] load_data;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dec_size   = SZ_WORD;
    dec_signed = 1'b0;
    dec_store  = 1'b0;
    dec_err    = 1'b0;
    if (req_fetch) begin
      dec_err = (addr[1:0] != 2'b00);
    end else begin
      case (opcode)
        OP_LB:  begin dec_size = SZ_BYTE; dec_signed = 1'b1; end
        OP_LBU: dec_size = SZ_BYTE;
        OP_LH:  begin dec_size = SZ_HALF; dec_signed = 1'b1; dec_err = addr[0]; end
        OP_LHU: begin dec_size = SZ_HALF; dec_err = addr[0]; end
        OP_LW:  dec_err = (addr[1:0] != 2'b00);
        OP_SB:  begin dec_size = SZ_BYTE; dec_store = 1'b1; end
        OP_SH:  begin dec_size = SZ_HALF; dec_store = 1'b1; dec_err = addr[0]; end
        OP_SW:  begin dec_store = 1'b1; dec_err = (addr[1:0] != 2'b00); end
        default: dec_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    dec_be    = 4'b1111;
    dec_wdata = wdata;
    case (dec_size)
      SZ_BYTE: begin
        dec_be    = 4'b0001 << addr[1:0];
        dec_wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        dec_be    = addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction of the returning read word
  assign rd_byte  = mem_readdata[{lane_q, 3'b000} +: 8];
  assign rd_half  = lane_q[1] ? mem_readdata[31:16] : mem_readdata[15:0];
  assign bus_done = (state_q == ACCESS) && !mem_waitrequest;

  always_comb begin
    load_data = mem_readdata;
    case (size_q)
      SZ_BYTE: load_data = {{24{signed_q & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_data = {{16{signed_q & rd_half[15]}}, rd_half};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = dec_err ? RESP : ACCESS;
      ACCESS:  if (!mem_waitrequest) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes follow the state register directly, so reset drops them at once
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    mem_read   = (state_q == ACCESS) && !store_q;
    mem_write  = (state_q == ACCESS) &&  store_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata          <= '0;
      err            <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= 4'b0000;
      mem_writedata  <= '0;
      size_q         <= SZ_WORD;
      signed_q       <= 1'b0;
      store_q        <= 1'b0;
      lane_q         <= 2'b00;
    end else if (state_q == IDLE && req_valid) begin
      if (dec_err) begin
        rdata <= '0;
        err   <= 1'b1;
      end else begin
        mem_address    <= {addr[DATA_W-1:2], 2'b00};
        mem_byteenable <= dec_be;
        mem_writedata  <= dec_wdata;
        size_q         <= dec_size;
        signed_q       <= dec_signed;
        store_q        <= dec_store;
        lane_q         <= addr[1:0];
      end
    end else if (bus_done) begin
      rdata <= store_q ? '0 : load_data;
      err   <= 1'b0;
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data and address width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port req_valid  input  1  core requests an access this cycle.
REQ-005 SHALL have port req_fetch  input  1  1 = instruction fetch (opcode ignored), 0 = data access.
REQ-006 SHALL have port opcode  input  6  MIPS primary opcode of the load/store.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port wdata  input  32  store data (rt), right-aligned.
REQ-009 SHALL have port req_ready  output  1  unit idle, request accepted this cycle.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  32  extended load / fetched word, valid with resp_valid.
REQ-012 SHALL have port err  output  1  misaligned or unsupported request, valid with resp_valid.
REQ-013 SHALL have ports mem_address(32), mem_read(1), mem_write(1), mem_byteenable(4), mem_writedata(32) as outputs, and mem_waitrequest(1), mem_readdata(32) as inputs, forming an Avalon-MM master.

Function
REQ-014 SHALL implement states IDLE, ACCESS, RESP.
REQ-015 SHALL in IDLE drive req_ready=1; req_valid=1 captures req_fetch, opcode, addr, wdata.
REQ-016 SHALL support loads lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101 and stores sb 101000, sh 101001, sw 101011.
REQ-017 SHALL flag err for: other opcodes when req_fetch=0; halfword with addr[0]=1; word or fetch with addr[1:0]!=0.
REQ-018 SHALL on an err request skip the bus and go IDLE->RESP; no mem_read/mem_write is asserted.
REQ-019 SHALL otherwise go IDLE->ACCESS, asserting mem_read (fetch/load) or mem_write (store) from the next cycle.
REQ-020 SHALL drive mem_address = {addr[31:2],2'b00} in ACCESS.
REQ-021 SHALL use little-endian lanes: byte at addr[1:0]=k occupies bits [8k+7:8k].
REQ-022 SHALL set byteenable: word/fetch 1111; half 0011 or 1100 by addr[1]; byte one-hot 1<<addr[1:0].
REQ-023 SHALL replicate store data: sb {4{wdata[7:0]}}, sh {2{wdata[15:0]}}, sw wdata.
REQ-024 SHALL hold all mem_* outputs stable while mem_waitrequest=1; ACCESS has no timeout.
REQ-025 SHALL on mem_waitrequest=0 in ACCESS capture mem_readdata (reads), deassert mem_read/mem_write next cycle, go RESP.
REQ-026 SHALL extract loads: lb/lh sign-extend, lbu/lhu zero-extend the selected lane; lw/fetch pass the word.
REQ-027 SHALL in RESP assert resp_valid for exactly one cycle, then return to IDLE; stores/err return rdata=0.
REQ-028 SHALL hold rdata and err stable until the next resp_valid.
REQ-029 SHALL give minimum latency: accept cycle N, bus cycle N+1, resp_valid N+2 (N+1 for err), +1 per waitrequest cycle.
REQ-030 SHALL ignore req_valid when not in IDLE (req_ready=0); no queueing.
REQ-031 SHALL never assert mem_read and mem_write together.

Reset
REQ-032 SHALL on reset=0 immediately enter IDLE and clear mem_read, mem_write, resp_valid, err, rdata, mem_address, mem_byteenable, mem_writedata to 0, regardless of clock.
REQ-033 SHALL abandon an in-flight access on reset with no response; the first request after reset release is handled normally.

Verification
REQ-034 SHALL cover: lb at 0x1003, mem_readdata=0x80FF_0000, no wait -> mem_address 0x1000, byteenable 1000, rdata 0xFFFF_FF80, resp_valid at N+2.
REQ-035 SHALL cover: lhu at 0x2002, readdata 0xBEEF_1234, 3 waitrequest cycles -> signals stable 3 cycles, byteenable 1100, rdata 0x0000_BEEF, resp_valid at N+5.
REQ-036 SHALL cover: sb at 0x3001, wdata 0x1234_56AB -> mem_write=1, byteenable 0010, writedata 0xABAB_ABAB, rdata 0, err 0.
REQ-037 SHALL cover: lw at 0x4002 -> no bus activity, resp_valid at N+1 with err=1; opcode 001000 data access -> err=1.
REQ-038 SHALL cover: fetch at 0xBFC0_0000 with reset=0 asserted mid-ACCESS -> mem_read drops without a clock edge, no resp_valid, next fetch completes normally.
